// File: rtl/bcd_addsub_serial.sv
// Digit-serial packed-BCD adder/subtractor, least-significant digit first.
// Subtraction yields sign + magnitude through a 10's-complement fix-up pass when a < b.
module bcd_addsub_serial #(
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  mode,
   input  logic [4*DIGITS-1:0]   a,
   input  logic [4*DIGITS-1:0]   b,
   input  logic                  cin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   result,
   output logic                  cout,
   output logic                  neg,
   output logic                  err
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHK,
      S_CALC,
      S_FIX,
      S_DONE
   } state_t;

   state_t                    state_reg, state_next;
   logic [DIGITS-1:0][3:0]    a_reg, a_next;
   logic [DIGITS-1:0][3:0]    b_reg, b_next;
   logic [DIGITS-1:0][3:0]    result_reg, result_next;
   logic                      mode_reg, mode_next;
   logic                      cin_reg, cin_next;
   logic                      carry_reg, carry_next;
   logic [IW-1:0]             idx_reg, idx_next;
   logic                      cout_reg, cout_next;
   logic                      neg_reg, neg_next;
   logic                      err_reg, err_next;

   logic [DIGITS-1:0]         bad_digit;
   logic [3:0]                op_x;
   logic [3:0]                op_y;
   logic [4:0]                digit_sum;
   logic [3:0]                digit_out;
   logic                      digit_carry;
   logic                      last_digit;

   // Any captured nibble above 9 in either operand makes the operation invalid.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_chk
      assign bad_digit[gi] = (a_reg[gi] > 4'd9) || (b_reg[gi] > 4'd9);
   end

   assign last_digit = (idx_reg == IW'(DIGITS - 1));

   // One decimal digit step: CALC adds a (+ b or 9's complement of b), FIX complements the result digit.
   always_comb begin
      op_x = a_reg[idx_reg];
      op_y = mode_reg ? (4'd9 - b_reg[idx_reg]) : b_reg[idx_reg];
      if (state_reg == S_FIX) begin
         op_x = 4'd9 - result_reg[idx_reg];
         op_y = 4'd0;
      end
      digit_sum = {1'b0, op_x} + {1'b0, op_y} + {4'd0, carry_reg};
      if (digit_sum > 5'd9) begin
         digit_out   = 4'(digit_sum - 5'd10);
         digit_carry = 1'b1;
      end else begin
         digit_out   = digit_sum[3:0];
         digit_carry = 1'b0;
      end
   end

   always_comb begin
      state_next  = state_reg;
      a_next      = a_reg;
      b_next      = b_reg;
      result_next = result_reg;
      mode_next   = mode_reg;
      cin_next    = cin_reg;
      carry_next  = carry_reg;
      idx_next    = idx_reg;
      cout_next   = cout_reg;
      neg_next    = neg_reg;
      err_next    = err_reg;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               a_next      = a;
               b_next      = b;
               mode_next   = mode;
               cin_next    = cin;
               result_next = '0;
               cout_next   = 1'b0;
               neg_next    = 1'b0;
               err_next    = 1'b0;
               state_next  = S_CHK;
            end
         end
         S_CHK: begin
            if (|bad_digit) begin
               err_next    = 1'b1;
               result_next = '0;
               cout_next   = 1'b0;
               neg_next    = 1'b0;
               state_next  = S_DONE;
            end else begin
               idx_next    = '0;
               carry_next  = mode_reg ? 1'b1 : cin_reg;
               state_next  = S_CALC;
            end
         end
         S_CALC: begin
            result_next[idx_reg] = digit_out;
            carry_next           = digit_carry;
            idx_next             = idx_reg + IW'(1);
            if (last_digit) begin
               if (!mode_reg) begin
                  cout_next  = digit_carry;
                  state_next = S_DONE;
               end else if (digit_carry) begin
                  state_next = S_DONE;
               end else begin
                  // No borrow-free carry out means a < b: complement the raw difference.
                  neg_next   = 1'b1;
                  carry_next = 1'b1;
                  idx_next   = '0;
                  state_next = S_FIX;
               end
            end
         end
         S_FIX: begin
            result_next[idx_reg] = digit_out;
            carry_next           = digit_carry;
            idx_next             = idx_reg + IW'(1);
            if (last_digit) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= S_IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         result_reg <= '0;
         mode_reg   <= 1'b0;
         cin_reg    <= 1'b0;
         carry_reg  <= 1'b0;
         idx_reg    <= '0;
         cout_reg   <= 1'b0;
         neg_reg    <= 1'b0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         a_reg      <= a_next;
         b_reg      <= b_next;
         result_reg <= result_next;
         mode_reg   <= mode_next;
         cin_reg    <= cin_next;
         carry_reg  <= carry_next;
         idx_reg    <= idx_next;
         cout_reg   <= cout_next;
         neg_reg    <= neg_next;
         err_reg    <= err_next;
      end
   end

   assign busy   = (state_reg == S_CHK) || (state_reg == S_CALC) || (state_reg == S_FIX);
   assign done   = (state_reg == S_DONE);
   assign result = result_reg;
   assign cout   = cout_reg;
   assign neg    = neg_reg;
   assign err    = err_reg;

endmodule

// File: tb/tb_bcd_addsub_serial.sv
// Bench for bcd_addsub_serial: directed corner cases plus random operations
// compared against an integer-arithmetic reference model.
module tb_bcd_addsub_serial;

   localparam int D = 4;
   localparam int W = 4 * D;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          mode;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          cin;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          cout;
   logic          neg;
   logic          err;

   int            vectors = 0;
   int            miscompares = 0;
   logic [W-1:0]  prev_result;

   bcd_addsub_serial #(.DIGITS(D)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .mode   (mode),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .neg    (neg),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int bcd2int(input logic [W-1:0] v);
      int r = 0;
      for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
      return r;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int v);
      logic [W-1:0] r = '0;
      int x = v;
      for (int i = 0; i < D; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand_bcd();
      logic [W-1:0] r;
      for (int i = 0; i < D; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
      return r;
   endfunction

   // One complete operation; start is driven in the cycle after the call begins.
   task automatic run_op(input logic m, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic c, input bit glitch);
      int           ia, ib, s, n, lat;
      bit           bad, got;
      logic [W-1:0] exp_res;
      logic         exp_cout, exp_neg, exp_err;

      bad = 0;
      for (int i = 0; i < D; i++)
         if (av[i*4 +: 4] > 4'd9 || bv[i*4 +: 4] > 4'd9) bad = 1;
      ia = bcd2int(av);
      ib = bcd2int(bv);
      exp_cout = 0; exp_neg = 0; exp_err = 0;
      if (bad) begin
         exp_err = 1; exp_res = '0; lat = 2;
      end else if (!m) begin
         s = ia + ib + int'(c);
         exp_res = int2bcd(s % 10000);
         exp_cout = (s >= 10000);
         lat = D + 2;
      end else if (ia >= ib) begin
         exp_res = int2bcd(ia - ib); lat = D + 2;
      end else begin
         exp_res = int2bcd(ib - ia); exp_neg = 1; lat = 2 * D + 2;
      end

      @(posedge clk); #1;
      check("hold_result", 32'(result), 32'(prev_result));
      start = 1'b1; mode = m; a = av; b = bv; cin = c;
      n = 0; got = 0;
      while (n < 40 && !got) begin
         @(posedge clk); #1;
         n++;
         start = 1'b0;
         a = W'($urandom); b = W'($urandom); mode = 1'($urandom); cin = 1'($urandom);
         if (glitch && (n == 2 || n == 3)) start = 1'b1;
         if (done === 1'b1) got = 1;
         else check("busy_high", 32'(busy), 32'd1);
      end
      start = 1'b0;
      check("latency", 32'(n), 32'(lat));
      check("result", 32'(result), 32'(exp_res));
      check("cout", 32'(cout), 32'(exp_cout));
      check("neg", 32'(neg), 32'(exp_neg));
      check("err", 32'(err), 32'(exp_err));
      check("busy_at_done", 32'(busy), 32'd0);
      $display("op mode=%0d a=%h b=%h cin=%0d -> result=%h cout=%0d neg=%0d err=%0d lat=%0d",
               m, av, bv, c, result, cout, neg, err, n);
      prev_result = exp_res;
   endtask

   initial begin
      int seen;
      rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0; cin = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", 32'(result), 32'd0);
      check("rst_flags", {29'd0, cout, neg, err}, 32'd0);
      prev_result = '0;

      run_op(1'b0, 16'h1234, 16'h5678, 1'b0, 0);
      run_op(1'b0, 16'h9999, 16'h0000, 1'b1, 0);
      run_op(1'b0, 16'h9999, 16'h9999, 1'b1, 0);
      run_op(1'b1, 16'h5000, 16'h1234, 1'b0, 0);
      run_op(1'b1, 16'h0005, 16'h0005, 1'b1, 0);
      run_op(1'b1, 16'h0006, 16'h0009, 1'b0, 0);
      run_op(1'b1, 16'h0000, 16'h9999, 1'b0, 0);
      run_op(1'b0, 16'h12A4, 16'h0000, 1'b0, 0);
      run_op(1'b0, 16'h0001, 16'h0002, 1'b0, 0);
      run_op(1'b1, 16'h0000, 16'hF000, 1'b0, 0);
      run_op(1'b1, 16'h0010, 16'h0421, 1'b0, 1);
      run_op(1'b0, 16'h4321, 16'h1111, 1'b1, 1);

      // Reset in the middle of CALC aborts the operation with no done pulse.
      @(posedge clk); #1;
      start = 1'b1; mode = 1'b0; a = 16'h1111; b = 16'h2222; cin = 1'b0;
      @(posedge clk); #1 start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_result", 32'(result), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done === 1'b1) seen++;
      end
      check("abort_no_done", 32'(seen), 32'd0);
      prev_result = '0;

      for (int k = 0; k < 40; k++) begin
         logic [W-1:0] ra, rb;
         ra = rand_bcd();
         rb = rand_bcd();
         if (k % 8 == 7) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
         run_op(1'($urandom), ra, rb, 1'($urandom), bit'(k % 5 == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
